// File: rtl/instr_prefetch_pkg.sv
// Shared constants for the instruction prefetch queue: default geometry and queue entry layout.
package instr_prefetch_pkg;

  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DATA_WIDTH         = 8;

  // Each queue entry carries the program byte plus the address it was fetched from.
  function automatic int entryWidth(input int addrWidth);
    return DATA_WIDTH + addrWidth;
  endfunction

endpackage

// File: rtl/instr_prefetch_byte_fifo.sv
// Small circular queue with synchronous flush; head is read from registered storage (no bypass).
module instr_prefetch_byte_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = entryWidth(DEFAULT_ADDR_WIDTH)
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  // Pops on an empty queue are dropped; a push into a full queue is only taken alongside a pop.
  assign doPop    = pop & (count != '0);
  assign doPush   = push & ((count != CW'(DEPTH)) | doPop);
  assign headData = storage[rdPtr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        storage[wrPtr] <= pushData;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Prefetch queue between program memory (1-cycle synchronous read) and the processor.
// Holds the fetch pointer, the single outstanding-read flag and jump redirect; bytes buffer in a FIFO.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  input  logic [7:0]            memDataRead,
  output logic [7:0]            outByte,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic                  outValid,
  input  logic                  outReady,
  input  logic                  jumpValid,
  input  logic [ADDR_WIDTH-1:0] jumpAddr
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = entryWidth(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] fetchPc;
  logic [ADDR_WIDTH-1:0] tagAddr;
  logic                  inFlight;
  logic [CW-1:0]         count;
  logic [CW:0]           used;
  logic                  flush;
  logic [EW-1:0]         headData;

  assign flush = reset | jumpValid;

  // A read is only issued when the queue has room for it and any response already in flight.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inFlight};
  assign memStrobe = ~flush & (used < (CW+1)'(DEPTH));
  assign memAddr   = fetchPc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= '0;
      tagAddr  <= '0;
      inFlight <= 1'b0;
    end else if (jumpValid) begin
      fetchPc  <= jumpAddr;
      inFlight <= 1'b0;
    end else begin
      inFlight <= memStrobe;
      if (memStrobe) begin
        fetchPc <= fetchPc + 1'b1;
        tagAddr <= fetchPc;
      end
    end
  end

  instr_prefetch_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .flush    (flush),
    .push     (inFlight & ~flush),
    .pushData ({memDataRead, tagAddr}),
    .pop      (outReady & ~flush),
    .headData (headData),
    .count    (count)
  );

  assign outValid = (count != '0);
  assign outByte  = headData[EW-1 -: 8];
  assign outAddr  = headData[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench: flushes queue an expected sequential byte stream; a negedge monitor checks every pop.
module tb_instr_prefetch;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] memAddr;
  logic          memStrobe;
  logic [7:0]    memDataRead = 8'h00;
  logic [7:0]    outByte;
  logic [AW-1:0] outAddr;
  logic          outValid;
  logic          outReady = 1'b0;
  logic          jumpValid = 1'b0;
  logic [AW-1:0] jumpAddr = '0;

  instr_prefetch #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .memAddr     (memAddr),
    .memStrobe   (memStrobe),
    .memDataRead (memDataRead),
    .outByte     (outByte),
    .outAddr     (outAddr),
    .outValid    (outValid),
    .outReady    (outReady),
    .jumpValid   (jumpValid),
    .jumpAddr    (jumpAddr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (memStrobe) memDataRead <= mem[memAddr];
  end

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: after a flush to address A the consumer must see A, A+1, ... (mod 256).
  task automatic refill(input logic [7:0] startAddr);
    logic [7:0] a;
    expQ.delete();
    a = startAddr;
    for (int i = 0; i < 600; i++) begin
      expQ.push_back('{addr: a, data: mem[a]});
      a = a + 8'd1;
    end
  endtask

  int   sinceFlush = 1000;
  int   outstanding = 0;
  int   pops = 0;
  int   strobes = 0;
  exp_t e;

  always @(negedge clk) begin
    if (reset || jumpValid) begin
      check("strobe_during_flush", int'(memStrobe), 0);
      sinceFlush  = 0;
      outstanding = 0;
      pops        = 0;
      strobes     = 0;
    end else begin
      if (sinceFlush < 1000) sinceFlush++;
      if (sinceFlush == 1 || sinceFlush == 2) check("outvalid_before_latency", int'(outValid), 0);
      if (sinceFlush == 1) check("strobe_after_flush", int'(memStrobe), 1);
      if (sinceFlush == 3) check("outvalid_latency", int'(outValid), 1);
      if (outValid && outReady) begin
        pops++;
        outstanding--;
        check("exp_queue_nonempty", int'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("out_addr", int'(outAddr), int'(e.addr));
          check("out_byte", int'(outByte), int'(e.data));
        end
      end
      if (memStrobe) begin
        strobes++;
        outstanding++;
      end
      check("credit_bound", int'(outstanding <= DEPTH), 1);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    reset     = 1'b1;
    jumpValid = 1'b0;
    refill(8'h00);
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic doJump(input logic [7:0] a);
    jumpValid = 1'b1;
    jumpAddr  = a;
    refill(a);
    cycle();
    jumpValid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE6;
    mem[1] = 8'h12;
    mem[2] = 8'h34;
    mem[3] = 8'hFF;
    cycle();

    // 1: reset release streams E6 12 34 FF from 00..03, one per cycle
    outReady = 1'b1;
    doReset(2);
    repeat (6) cycle();
    check("t1_pops", pops, 4);
    repeat (4) cycle();

    // 2: consumer stalled -> exactly DEPTH reads, then resume one cycle after ready
    outReady = 1'b0;
    doReset(1);
    repeat (10) cycle();
    check("t2_strobes", strobes, DEPTH);
    check("t2_full_no_strobe", int'(memStrobe), 0);
    outReady = 1'b1;
    @(negedge clk);
    check("t2_no_strobe_pop_cycle", int'(memStrobe), 0);
    @(negedge clk);
    check("t2_strobe_resumes", int'(memStrobe), 1);
    cycle();
    repeat (8) cycle();

    // 3: jump with 3 queued + 1 in flight
    outReady = 1'b0;
    doReset(1);
    repeat (4) cycle();
    doJump(8'h40);
    outReady = 1'b1;
    repeat (10) cycle();

    // 4: address wrap FD, FE, FF, 00, 01
    outReady = 1'b1;
    doJump(8'hFD);
    repeat (8) cycle();
    check("t4_pops", pops, 6);

    // 6: reset mid-stream with full queue
    outReady = 1'b0;
    doReset(1);
    repeat (8) cycle();
    doReset(2);
    outReady = 1'b1;
    repeat (6) cycle();
    check("t6_pops", pops, 4);

    // 5: random consumer back-pressure with occasional redirects
    for (int i = 0; i < 500; i++) begin
      outReady = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        jumpValid = 1'b1;
        jumpAddr  = 8'($urandom);
        refill(jumpAddr);
      end else begin
        jumpValid = 1'b0;
      end
      cycle();
    end
    jumpValid = 1'b0;
    outReady  = 1'b1;
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
